// File: rtl/cic_pkg.sv
// Shared definitions for the CIC decimator chain: compensation FIR coefficients,
// fixed-point constants, the FIR state encoding and accumulator sizing.
package cic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int COMP_FRAC      = 14;
    localparam int COMP_COEF_BITS = 16;
    localparam int COMP_TAPS      = 7;

    // Symmetric droop compensator; the taps sum to 16384 (1.0) for unity DC gain.
    localparam logic signed [COMP_COEF_BITS-1:0] COMP_COEF [COMP_TAPS] = '{
        -16'sd512, 16'sd0, 16'sd4608, 16'sd8192, 16'sd4608, 16'sd0, -16'sd512
    };

    // Full-precision width of a sum of `taps` products, so the MAC never overflows.
    function automatic int acc_width(input int bits, input int coef_bits, input int taps);
        return bits + coef_bits + $clog2(taps);
    endfunction

endpackage

// File: rtl/cic_round_sat.sv
// Combinational round-half-up and saturate from a wide signed value to OUT_W bits.
// Shared by the compensation FIR and the CIC output trim.
module cic_round_sat #(
    parameter int IN_W  = 35,
    parameter int OUT_W = 16,
    parameter int SHIFT = 14
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    // One guard bit keeps the rounding offset from wrapping a near-full-scale input.
    localparam int SW = IN_W + 1;

    localparam logic signed [SW-1:0] HALF    = SW'(64'sd1 <<< (SHIFT - 1));
    localparam logic signed [SW-1:0] OUT_MAX = SW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] OUT_MIN = SW'(-(64'sd1 <<< (OUT_W - 1)));

    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] shifted;

    assign sum     = SW'(din) + HALF;
    assign shifted = sum >>> SHIFT;

    always_comb begin
        if (shifted > OUT_MAX) begin
            dout = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (shifted < OUT_MIN) begin
            dout = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            dout = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/cic_comp_fir.sv
// Serial-MAC symmetric compensation FIR behind the CIC decimator: one multiplier
// time-shared over TAPS cycles, one output per accepted sample.
module cic_comp_fir
    import cic_pkg::*;
#(
    parameter int BITS      = 16,
    parameter int TAPS      = COMP_TAPS,
    parameter int COEF_BITS = COMP_COEF_BITS,
    parameter int FRAC      = COMP_FRAC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [BITS-1:0] stream_in,
    input  logic                   valid,
    output logic                   in_ready,
    output logic signed [BITS-1:0] stream_out,
    output logic                   out_valid,
    output logic                   overrun
);

    localparam int ACC_W  = acc_width(BITS, COEF_BITS, TAPS);
    localparam int PROD_W = BITS + COEF_BITS;
    localparam int KW     = (TAPS > 1) ? $clog2(TAPS) : 1;

    state_t state;
    state_t state_nxt;

    logic        [KW-1:0]        k;
    logic signed [BITS-1:0]      x [TAPS];
    logic signed [ACC_W-1:0]     acc;
    logic signed [COEF_BITS-1:0] coef;
    logic signed [PROD_W-1:0]    prod;
    logic signed [BITS-1:0]      trimmed;

    assign in_ready = (state == IDLE);
    assign coef     = COMP_COEF[k];
    assign prod     = PROD_W'(x[k]) * PROD_W'(coef);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; combinational blocks use blocking (=).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: next-state gets its default before the case so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (valid) state_nxt = MAC;
            MAC:     if (k == KW'(TAPS - 1)) state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the delay line is reset, unlike a typical data RAM, so the first
    // output after reset only sees post-reset samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) x[i] <= '0;
            acc        <= '0;
            k          <= '0;
            stream_out <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (valid && !in_ready) overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (valid) begin
                        x[0] <= stream_in;
                        for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
                        acc <= '0;
                        k   <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    k   <= k + KW'(1);
                end
                OUT: begin
                    stream_out <= trimmed;
                    out_valid  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    cic_round_sat #(
        .IN_W  (ACC_W),
        .OUT_W (BITS),
        .SHIFT (FRAC)
    ) u_round_sat (
        .din  (acc),
        .dout (trimmed)
    );

endmodule
